fir_axil_cfg_master: RTL and testbench
======================================

Name: fir_axil_cfg_master

Overview:
AXI4-Lite initiator that configures the fir block's AXI-Lite slave and starts it. On one start pulse it:
- writes the data length;
- writes all Tape_Num tap coefficients, then reads each back and checks it;
- writes ap_start, then polls ap_ctrl until ap_done.
It sits between the testbench or CPU-side control logic and the fir AXI-Lite port. It replaces hand-written bus sequences.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- Tape_Num, 11, number of taps; maximum 16.
- pPOLL_GAP, 4, idle cycles between ap_ctrl poll reads.
- pPOLL_MAX, 1024, maximum poll reads before timeout.

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle request to run the sequence.
- cfg_len  in  32  data length; captured on an accepted cfg_start.
- coef_idx  out  4  tap index presented to the coefficient source.
- coef_data  in  32  coefficient for coef_idx; combinational, stable while busy.
- cfg_busy  out  1  sequence in progress.
- cfg_done  out  1  one-cycle pulse at the end of the sequence (success or error).
- cfg_err  out  1  last sequence failed; held until the next accepted cfg_start.
- err_code  out  2  0 = none, 1 = tap readback mismatch, 2 = poll timeout.
- awvalid  out  1, awready  in  1, awaddr  out  pADDR_WIDTH: write address channel.
- wvalid  out  1, wready  in  1, wdata  out  pDATA_WIDTH: write data channel.
- arvalid  out  1, arready  in  1, araddr  out  pADDR_WIDTH: read address channel.
- rvalid  in  1, rready  out  1, rdata  in  pDATA_WIDTH: read data channel.

Behaviour:
- Reset (async, immediate): all valids, rready, cfg_busy, cfg_done, cfg_err deassert; awaddr/araddr/wdata/coef_idx/err_code = 0; state IDLE.
- Address map:
  - 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle.
  - 0x10 data length.
  - 0x20 + 4*i tap i.
- Write transaction:
  - awvalid and wvalid assert in the same cycle, with addr/data registered and stable.
  - Each valid drops the cycle after its own handshake (valid and ready both high).
  - The transaction is complete once both handshakes have occurred, in either order or the same cycle.
  - There is no B channel.
- Read transaction:
  - arvalid holds until arready; rready asserts the cycle after the AR handshake.
  - rdata is captured when rvalid and rready are both high; rready drops the next cycle.
  - Only one transaction is outstanding at a time. Write and read never overlap.
- No valid ever drops before its handshake.
- States:
  - IDLE: cfg_start -> capture cfg_len; clear cfg_err and err_code; set cfg_busy; go to WR_LEN. cfg_start while busy is ignored.
  - WR_LEN: write cfg_len to 0x10 -> WR_TAP with idx = 0.
  - WR_TAP: write coef_data to 0x20 + 4*idx. idx = Tape_Num-1 -> RD_TAP with idx = 0; else idx+1.
  - RD_TAP: read 0x20 + 4*idx; compare the captured rdata to coef_data.
    - Mismatch -> ERR with code 1.
    - idx = Tape_Num-1 -> WR_START; else idx+1.
  - WR_START: write 0x00 with data 1 -> POLL; poll counter = 0.
  - POLL: wait pPOLL_GAP cycles, then read 0x00.
    - bit1 set -> FIN.
    - Else increment the counter; counter reaching pPOLL_MAX -> ERR with code 2.
  - FIN: cfg_done = 1 for one cycle; cfg_busy = 0; -> IDLE.
  - ERR: cfg_err = 1; cfg_done = 1 for one cycle; cfg_busy = 0; -> IDLE. The sequence is not started after a mismatch.
- coef_idx = idx register in all states.
- cfg_busy is high from the cycle after an accepted cfg_start through the cycle before cfg_done.
- Reset mid-transaction abandons the bus immediately. The slave is assumed reset together with this block.

Decomposition:
- Package fir_cfg_pkg holds:
  - register offsets: ADDR_AP_CTRL = 0x00, ADDR_LEN = 0x10, ADDR_TAP_BASE = 0x20;
  - ap_ctrl bit positions;
  - the err_code enumeration;
  - the state enumeration.
- One sub-module, axil_master_xact: a single-transaction AXI-Lite write/read engine.
  - Inputs: req, we, addr, wdata.
  - Outputs: ack, rdata.
  - The sequencer FSM instantiates it once.

Test Plan:
- Slave model with awready/wready always high and 1-cycle read latency; cfg_len = 600, coef i = i+1:
  - writes seen in order: 0x10 = 600, 0x20..0x48 = 1..11, 0x00 = 1;
  - 11 reads follow the tap writes;
  - ap_done set on the 3rd poll -> cfg_done pulse, cfg_err = 0.
- wready asserted 3 cycles after awready, and the reverse on alternate writes -> each write completes exactly once, wdata stable while wvalid is high, no lost writes.
- Slave corrupts the tap-5 readback (returns 0xDEAD) -> ERR with err_code = 1, cfg_done pulse, no write to 0x00.
- ap_done never set with pPOLL_MAX = 8 -> exactly 8 reads of 0x00, each separated by ≥4 idle cycles, then err_code = 2.
- cfg_start pulsed again during WR_TAP -> ignored; only one sequence of writes is seen.
- axis_rst asserted while awvalid is high -> awvalid, wvalid and cfg_busy are low the same cycle; a new cfg_start after reset runs the full sequence.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// Shared register map, ap_ctrl bit positions, error codes and
// sequencer states for the fir AXI-Lite configuration master.
package fir_cfg_pkg;

  localparam logic [7:0] ADDR_AP_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_LEN      = 8'h10;
  localparam logic [7:0] ADDR_TAP_BASE = 8'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TAP     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_TAP,
    S_RD_TAP,
    S_WR_START,
    S_POLL,
    S_FIN,
    S_ERR
  } state_e;

  function automatic logic [7:0] tap_addr(input logic [3:0] idx);
    return ADDR_TAP_BASE + {2'b00, idx, 2'b00};
  endfunction

endpackage

// File: rtl/axil_master_xact.sv
// Single-transaction AXI-Lite engine: req/we/addr/wdata in, ack pulse
// and registered rdata out; drives AW/W/AR/R, no B channel.
module axil_master_xact #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   ack,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] axi_wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] axi_rdata
);

  logic busy;
  logic we_q;
  logic aw_ok;
  logic w_ok;
  logic aw_hs;
  logic w_hs;
  logic wr_fin;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  // AW and W may complete in either order or together
  assign wr_fin = we_q && (aw_ok || aw_hs) && (w_ok || w_hs);

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      busy      <= 1'b0;
      we_q      <= 1'b0;
      aw_ok     <= 1'b0;
      w_ok      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      axi_wdata <= '0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!busy) begin
        if (req) begin
          busy  <= 1'b1;
          we_q  <= we;
          aw_ok <= 1'b0;
          w_ok  <= 1'b0;
          if (we) begin
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            awaddr    <= addr;
            axi_wdata <= wdata;
          end else begin
            arvalid <= 1'b1;
            araddr  <= addr;
          end
        end
      end else begin
        if (aw_hs) begin
          awvalid <= 1'b0;
          aw_ok   <= 1'b1;
        end
        if (w_hs) begin
          wvalid <= 1'b0;
          w_ok   <= 1'b1;
        end
        if (wr_fin) begin
          busy <= 1'b0;
          ack  <= 1'b1;
        end
        if (arvalid && arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        if (rready && rvalid) begin
          rready <= 1'b0;
          rdata  <= axi_rdata;
          busy   <= 1'b0;
          ack    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fir_axil_cfg_master.sv
// Sequencer: writes length and taps, verifies taps by readback, starts
// fir and polls ap_done; reports cfg_busy/cfg_done/cfg_err/err_code.
module fir_axil_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pPOLL_GAP   = 4,
  parameter int pPOLL_MAX   = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  output logic [3:0]             coef_idx,
  input  logic [31:0]            coef_data,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [1:0]             err_code,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  import fir_cfg_pkg::*;

  localparam int PW = $clog2(pPOLL_MAX + 1);
  localparam int GW = $clog2(pPOLL_GAP + 2);
  localparam logic [3:0]    LAST_IDX = 4'(Tape_Num - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(pPOLL_MAX - 1);
  localparam logic [GW-1:0] GAP_END = GW'(pPOLL_GAP);

  state_e                 state_q;
  state_e                 state_d;
  logic [3:0]             idx_q;
  logic [31:0]            len_q;
  logic [PW-1:0]          poll_q;
  logic [GW-1:0]          gap_q;
  logic                   pend_q;
  err_code_e              err_q;
  logic                   err_flag_q;

  logic                   req;
  logic                   we;
  logic [pADDR_WIDTH-1:0] addr;
  logic [pDATA_WIDTH-1:0] xdata;
  logic                   ack;
  logic [pDATA_WIDTH-1:0] rd_q;

  logic last;
  logic mismatch;
  logic done_bit;
  logic poll_last;

  assign last      = (idx_q == LAST_IDX);
  assign mismatch  = (rd_q != pDATA_WIDTH'(coef_data));
  assign done_bit  = rd_q[AP_DONE_BIT];
  assign poll_last = (poll_q == POLL_LAST);

  assign coef_idx = idx_q;
  assign cfg_err  = err_flag_q;
  assign err_code = err_q;

  axil_master_xact #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_xact (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (xdata),
    .ack      (ack),
    .rdata    (rd_q),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .axi_wdata(wdata),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .axi_rdata(rdata)
  );

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (cfg_start) state_d = S_WR_LEN;
      S_WR_LEN:   if (ack) state_d = S_WR_TAP;
      S_WR_TAP:   if (ack && last) state_d = S_RD_TAP;
      S_RD_TAP: begin
        if (ack) begin
          if (mismatch)  state_d = S_ERR;
          else if (last) state_d = S_WR_START;
        end
      end
      S_WR_START: if (ack) state_d = S_POLL;
      S_POLL: begin
        if (ack) begin
          if (done_bit)       state_d = S_FIN;
          else if (poll_last) state_d = S_ERR;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // req is raised once per bus state; pend_q masks it until ack
  always_comb begin
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    xdata    = '0;
    cfg_busy = 1'b1;
    cfg_done = 1'b0;
    unique case (state_q)
      S_IDLE: cfg_busy = 1'b0;
      S_WR_LEN: begin
        req   = !pend_q;
        we    = 1'b1;
        addr  = pADDR_WIDTH'(ADDR_LEN);
        xdata = pDATA_WIDTH'(len_q);
      end
      S_WR_TAP: begin
        req   = !pend_q;
        we    = 1'b1;
        addr  = pADDR_WIDTH'(tap_addr(idx_q));
        xdata = pDATA_WIDTH'(coef_data);
      end
      S_RD_TAP: begin
        req  = !pend_q;
        addr = pADDR_WIDTH'(tap_addr(idx_q));
      end
      S_WR_START: begin
        req  = !pend_q;
        we   = 1'b1;
        addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        xdata[AP_START_BIT] = 1'b1;
      end
      S_POLL: begin
        req  = !pend_q && (gap_q == GAP_END);
        addr = pADDR_WIDTH'(ADDR_AP_CTRL);
      end
      default: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b1;
      end
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      idx_q      <= '0;
      len_q      <= '0;
      poll_q     <= '0;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      err_q      <= ERR_NONE;
      err_flag_q <= 1'b0;
    end else begin
      if (ack)      pend_q <= 1'b0;
      else if (req) pend_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            len_q      <= cfg_len;
            idx_q      <= '0;
            err_q      <= ERR_NONE;
            err_flag_q <= 1'b0;
          end
        end
        S_WR_LEN: if (ack) idx_q <= '0;
        S_WR_TAP: if (ack) idx_q <= last ? 4'd0 : idx_q + 4'd1;
        S_RD_TAP: begin
          if (ack) begin
            if (mismatch) begin
              err_q      <= ERR_TAP;
              err_flag_q <= 1'b1;
            end else if (!last) begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_WR_START: begin
          if (ack) begin
            poll_q <= '0;
            gap_q  <= '0;
          end
        end
        S_POLL: begin
          if (!pend_q && gap_q != GAP_END) gap_q <= gap_q + 1'b1;
          if (ack && !done_bit) begin
            poll_q <= poll_q + 1'b1;
            gap_q  <= '0;
            if (poll_last) begin
              err_q      <= ERR_TIMEOUT;
              err_flag_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_axil_cfg_master.sv
// Scoreboard bench: stimulus queues expected writes, reads and done
// events; a negedge slave/monitor process pops and compares them.
module tb_fir_axil_cfg_master;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_len = '0;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  err_code;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [11:0] awaddr;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [31:0] wdata;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [11:0] araddr;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;

  always #5 axis_clk = ~axis_clk;

  assign coef_data = 32'(coef_idx) + 32'd1;

  fir_axil_cfg_master #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .Tape_Num   (11),
    .pPOLL_GAP  (4),
    .pPOLL_MAX  (8)
  ) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .cfg_start(cfg_start),
    .cfg_len  (cfg_len),
    .coef_idx (coef_idx),
    .coef_data(coef_data),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .err_code (err_code),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata)
  );

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [11:0] exp_rd[$];
  logic [2:0]  exp_done[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  int          dly_mode = 0;
  int          done_poll = 0;
  int          polls = 0;
  logic        bad_en = 1'b0;
  logic [11:0] bad_addr = '0;
  logic [31:0] mem [0:63];

  int          cyc = 0;
  int          wr_n = 0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  int          aw_dly;
  int          w_dly;
  logic        aw_got = 0;
  logic        w_got = 0;
  logic [11:0] aw_a;
  logic [31:0] w_d;
  logic        aw_hold = 0;
  logic        w_hold = 0;
  logic [11:0] aw_last;
  logic [31:0] w_last;
  logic        proto_bad = 0;
  logic        rd_pend = 0;
  logic        r_clear = 0;
  logic [31:0] rd_data;
  logic        prev_ctrl = 0;
  int          last_r_cyc = 0;
  wr_t         ew;
  logic [11:0] er;
  logic [2:0]  ed;

  // slave model and monitor
  initial begin
    forever begin
      @(negedge axis_clk);
      cyc++;
      if (axis_rst) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        aw_hold = 0; w_hold = 0; proto_bad = 0;
        rd_pend = 0; r_clear = 0; prev_ctrl = 0;
      end else begin
        if (aw_hold && (!awvalid || awaddr != aw_last)) proto_bad = 1;
        if (w_hold && (!wvalid || wdata != w_last)) proto_bad = 1;
        aw_dly = 0;
        w_dly = 0;
        if (dly_mode == 1) begin
          if (wr_n[0]) aw_dly = 3;
          else         w_dly = 3;
        end
        awready = awvalid && (aw_cnt >= aw_dly);
        wready  = wvalid && (w_cnt >= w_dly);
        if (awvalid) aw_cnt++;
        if (wvalid)  w_cnt++;
        aw_hold = awvalid && !awready;
        w_hold  = wvalid && !wready;
        aw_last = awaddr;
        w_last  = wdata;
        if (awvalid && awready) begin
          aw_a = awaddr; aw_got = 1; aw_cnt = 0;
        end
        if (wvalid && wready) begin
          w_d = wdata; w_got = 1; w_cnt = 0;
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; wr_n++;
          mem[aw_a[7:2]] = w_d;
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected got %h=%h required none", aw_a, w_d);
          end else begin
            ew = exp_wr.pop_front();
            if (ew.a != aw_a || ew.d != w_d || proto_bad) begin
              errors++;
              $display("FAIL write got %h=%h proto_bad=%0d required %h=%h proto_bad=0",
                       aw_a, w_d, proto_bad, ew.a, ew.d);
            end
          end
          proto_bad = 0;
        end

        arready = 1;
        if (r_clear) begin rvalid = 0; r_clear = 0; end
        if (rd_pend) begin rvalid = 1; rdata = rd_data; rd_pend = 0; end
        if (rvalid && rready) begin r_clear = 1; last_r_cyc = cyc; end
        if (arvalid && arready) begin
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected got %h required none", araddr);
          end else begin
            er = exp_rd.pop_front();
            if (er != araddr) begin
              errors++;
              $display("FAIL read_addr got %h required %h", araddr, er);
            end
          end
          if (araddr == 12'h000) begin
            if (prev_ctrl) begin
              checks++;
              if (cyc - last_r_cyc - 1 < 4) begin
                errors++;
                $display("FAIL poll_gap got %0d required >=4", cyc - last_r_cyc - 1);
              end
            end
            polls++;
            rd_data = (done_poll != 0 && polls >= done_poll) ? 32'h6 : 32'h0;
          end else if (bad_en && araddr == bad_addr) begin
            rd_data = 32'hDEAD;
          end else begin
            rd_data = mem[araddr[7:2]];
          end
          prev_ctrl = (araddr == 12'h000);
          rd_pend = 1;
        end

        if (cfg_done) begin
          checks++;
          done_cnt++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got err=%0d code=%0d required none", cfg_err, err_code);
          end else begin
            ed = exp_done.pop_front();
            if ({cfg_err, err_code} != ed || cfg_busy) begin
              errors++;
              $display("FAIL done got err=%0d code=%0d busy=%0d required err=%0d code=%0d busy=0",
                       cfg_err, err_code, cfg_busy, ed[2], ed[1:0]);
            end
          end
        end
      end
    end
  end

  task automatic push_seq(input logic [31:0] len, input int nrd,
                          input bit wr_start, input int npoll,
                          input logic [2:0] dn);
    wr_t w;
    w.a = 12'h010; w.d = len;
    exp_wr.push_back(w);
    for (int i = 0; i < 11; i++) begin
      w.a = 12'(32'h20 + 4 * i);
      w.d = 32'(i + 1);
      exp_wr.push_back(w);
    end
    for (int i = 0; i < nrd; i++) exp_rd.push_back(12'(32'h20 + 4 * i));
    if (wr_start) begin
      w.a = 12'h000; w.d = 32'd1;
      exp_wr.push_back(w);
    end
    for (int i = 0; i < npoll; i++) exp_rd.push_back(12'h000);
    exp_done.push_back(dn);
  endtask

  task automatic pulse_start(input logic [31:0] len);
    @(posedge axis_clk); #1;
    cfg_start = 1; cfg_len = len;
    @(posedge axis_clk); #1;
    cfg_start = 0;
  endtask

  task automatic wait_done(input string name);
    int s;
    int n;
    s = done_cnt;
    n = 0;
    while (done_cnt == s && n < 2000) begin
      @(posedge axis_clk);
      n++;
    end
    if (done_cnt == s) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no cfg_done required cfg_done", name);
    end
    repeat (20) @(posedge axis_clk);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got wr=%0d rd=%0d done=%0d left required 0",
               name, exp_wr.size(), exp_rd.size(), exp_done.size());
    end
    exp_wr.delete(); exp_rd.delete(); exp_done.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #1 axis_rst = 1;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("reset_valids", 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
    chk("reset_status", 64'({cfg_busy, cfg_done, cfg_err, err_code}), 64'd0);
    chk("reset_regs", 64'({awaddr, araddr, wdata, coef_idx}), 64'd0);
    axis_rst = 0;
    repeat (2) @(posedge axis_clk);

    // basic sequence, ap_done on 3rd poll
    dly_mode = 0; done_poll = 3; polls = 0; bad_en = 0;
    push_seq(32'd600, 11, 1, 3, 3'b0_00);
    pulse_start(32'd600);
    wait_done("basic");
    check_drained("basic");

    // alternating AW/W ready skew
    dly_mode = 1; done_poll = 1; polls = 0;
    push_seq(32'd100, 11, 1, 1, 3'b0_00);
    pulse_start(32'd100);
    wait_done("skew");
    check_drained("skew");

    // tap 5 readback corrupted
    dly_mode = 0; done_poll = 1; polls = 0;
    bad_en = 1; bad_addr = 12'h034;
    push_seq(32'd50, 6, 0, 0, 3'b1_01);
    pulse_start(32'd50);
    wait_done("mismatch");
    check_drained("mismatch");
    bad_en = 0;

    // ap_done never set: 8 polls then timeout
    done_poll = 0; polls = 0;
    push_seq(32'd20, 11, 1, 8, 3'b1_10);
    pulse_start(32'd20);
    wait_done("timeout");
    check_drained("timeout");

    // second cfg_start while busy is ignored
    done_poll = 2; polls = 0;
    push_seq(32'd7, 11, 1, 2, 3'b0_00);
    pulse_start(32'd7);
    repeat (8) @(posedge axis_clk);
    pulse_start(32'd999);
    wait_done("restart");
    repeat (40) @(posedge axis_clk);
    #1;
    chk("restart_idle", 64'(cfg_busy), 64'd0);
    check_drained("restart");

    // reset while awvalid is high, then full rerun
    dly_mode = 1; done_poll = 1; polls = 0;
    pulse_start(32'd33);
    n = 0;
    while (!awvalid && n < 20) begin
      @(posedge axis_clk); #1;
      n++;
    end
    chk("rst_saw_awvalid", 64'(awvalid), 64'd1);
    #1 axis_rst = 1;
    #1;
    chk("rst_async", 64'({awvalid, wvalid, cfg_busy}), 64'd0);
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 0;
    exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    dly_mode = 0; polls = 0;
    push_seq(32'd600, 11, 1, 1, 3'b0_00);
    pulse_start(32'd600);
    wait_done("after_rst");
    check_drained("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
